// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer that accepts
// up to two instructions per cycle in program order and presents the two
// oldest entries combinationally at its head for up to two pops per cycle.
module inst_queue #(
  parameter int unsigned       DEPTH     = 16,
  parameter int unsigned       LOG_DEPTH = 4,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       META_W    = 80,
  parameter int unsigned       AFULL_TH  = 4,
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(32'h0340_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  // Write side: mask 00, 01 or 11; inst0 is older than inst1.
  input  logic [1:0]           in_valid,
  input  logic [DATA_W-1:0]    in_inst0,
  input  logic [DATA_W-1:0]    in_inst1,
  input  logic [META_W-1:0]    in_meta0,
  input  logic [META_W-1:0]    in_meta1,
  output logic                 in_ready,
  // Read side: the two oldest entries and how many the consumer takes.
  output logic [1:0]           out_valid,
  output logic [DATA_W-1:0]    out_inst0,
  output logic [DATA_W-1:0]    out_inst1,
  output logic [META_W-1:0]    out_meta0,
  output logic [META_W-1:0]    out_meta1,
  input  logic [1:0]           pop_cnt,
  // Occupancy status.
  output logic [LOG_DEPTH:0]   count,
  output logic                 empty,
  output logic                 nearly_full
);

  typedef logic [LOG_DEPTH-1:0] ptr_t;
  typedef logic [LOG_DEPTH:0]   cnt_t;

  // One storage slot: instruction word plus its opaque metadata.
  typedef struct packed {
    logic [META_W-1:0] meta;
    logic [DATA_W-1:0] inst;
  } entry_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t TWO_C   = cnt_t'(2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t mem_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  // ---------------------------------------------------------------------------
  // Derived status, all from registered occupancy
  // ---------------------------------------------------------------------------
  cnt_t       free_slots;
  logic [1:0] avail;      // entries presentable at the head: 0, 1 or 2
  logic [1:0] pop_req;    // pop_cnt with 3 folded down to 2
  logic [1:0] pop_eff;    // pop actually performed this cycle
  logic       wr_fire;    // at least one slot is written this cycle
  logic       wr_two;     // both slots are written this cycle
  logic [1:0] wr_num;     // number of slots written this cycle
  ptr_t       tail_p1;
  ptr_t       head_p1;

  assign free_slots = DEPTH_C - count_q;

  // Ready only looks at the registered count, so a pop in the same cycle
  // never makes room for a write; this keeps in_ready off the pop path.
  assign in_ready    = (free_slots >= TWO_C);
  assign nearly_full = (32'(free_slots) < AFULL_TH);
  assign empty       = (count_q == '0);
  assign count       = count_q;

  assign out_valid[0] = (count_q >= cnt_t'(1));
  assign out_valid[1] = (count_q >= TWO_C);

  assign tail_p1 = tail_q + ptr_t'(1);
  assign head_p1 = head_q + ptr_t'(1);

  // A write needs room for two and no flush; mask 10 has bit 0 clear and so
  // writes nothing. Room for two guarantees the count never passes DEPTH.
  assign wr_fire = in_ready & ~flush & in_valid[0];
  assign wr_two  = wr_fire & in_valid[1];
  assign wr_num  = {wr_two, wr_fire & ~in_valid[1]};

  // Effective pop: clamp the request to what is actually at the head, which
  // also makes underflow impossible whatever the consumer asks for.
  // NOTE: every signal written in an always_comb gets a value before any
  // branch, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    pop_req = 2'd0;
    avail   = 2'd0;
    pop_eff = 2'd0;

    case (pop_cnt)
      2'd0:    pop_req = 2'd0;
      2'd1:    pop_req = 2'd1;
      default: pop_req = 2'd2;
    endcase

    if (count_q >= TWO_C) begin
      avail = 2'd2;
    end else begin
      avail = count_q[1:0];
    end

    pop_eff = (pop_req > avail) ? avail : pop_req;
  end

  // Next-state pointers and count; a flush overrides any write or pop.
  always_comb begin
    head_d  = head_q + ptr_t'(pop_eff);
    tail_d  = tail_q + ptr_t'(wr_num);
    count_d = count_q + cnt_t'(wr_num) - cnt_t'(pop_eff);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot storage: written at tail and tail+1, never cleared.
  // NOTE: the storage array has no reset on purpose; validity lives entirely
  // in the pointers and count, and leaving the array unreset lets it map to
  // plain RAM or flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[tail_q] <= '{meta: in_meta0, inst: in_inst0};
    end
    if (wr_two) begin
      mem_q[tail_p1] <= '{meta: in_meta1, inst: in_inst1};
    end
  end

  // ---------------------------------------------------------------------------
  // Head read-out: combinational from storage, masked when the slot is empty
  // ---------------------------------------------------------------------------
  entry_t rd0;
  entry_t rd1;

  assign rd0 = mem_q[head_q];
  assign rd1 = mem_q[head_p1];

  // Invalid head slots show a NOP and zero metadata instead of stale storage.
  always_comb begin
    out_inst0 = NOP_INST;
    out_meta0 = '0;
    out_inst1 = NOP_INST;
    out_meta1 = '0;

    if (out_valid[0]) begin
      out_inst0 = rd0.inst;
      out_meta0 = rd0.meta;
    end
    if (out_valid[1]) begin
      out_inst1 = rd1.inst;
      out_meta1 = rd1.meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_count_bounded: assert property (
    @(posedge clk) disable iff (rst) count_q <= DEPTH_C
  );

  a_ptr_consistent: assert property (
    @(posedge clk) disable iff (rst) ptr_t'(head_q + ptr_t'(count_q)) == tail_q
  );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a queue model acts as scoreboard,
// receiving expected entries as writes are driven and giving them back as
// the DUT pops them.
module tb_inst_queue;

  localparam int DEPTH  = 16;
  localparam int LOG_D  = 4;
  localparam int DW     = 32;
  localparam int MW     = 80;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [DW-1:0] in_inst0 = '0;
  logic [DW-1:0] in_inst1 = '0;
  logic [MW-1:0] in_meta0 = '0;
  logic [MW-1:0] in_meta1 = '0;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [DW-1:0] out_inst0;
  logic [DW-1:0] out_inst1;
  logic [MW-1:0] out_meta0;
  logic [MW-1:0] out_meta1;
  logic [1:0]    pop_cnt = 2'd0;
  logic [LOG_D:0] count;
  logic          empty;
  logic          nearly_full;

  inst_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_inst0    (in_inst0),
    .in_inst1    (in_inst1),
    .in_meta0    (in_meta0),
    .in_meta1    (in_meta1),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_inst0   (out_inst0),
    .out_inst1   (out_inst1),
    .out_meta0   (out_meta0),
    .out_meta1   (out_meta1),
    .pop_cnt     (pop_cnt),
    .count       (count),
    .empty       (empty),
    .nearly_full (nearly_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] inst;
    logic [MW-1:0] meta;
  } ent_t;

  ent_t model_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Inputs presented for the cycle in flight and the model occupancy seen then.
  logic [1:0]  cur_v;
  logic [31:0] cur_i0;
  logic [31:0] cur_i1;
  logic [1:0]  cur_pc;
  logic        cur_fl;
  int          cur_occ;

  function automatic logic [MW-1:0] mk_meta(input logic [DW-1:0] inst);
    return {16'hC0DE, ~inst, inst};
  endfunction

  task automatic drive_set(input logic [1:0] v, input logic [31:0] i0,
                           input logic [31:0] i1, input logic [1:0] pc,
                           input logic fl);
    cur_v    = v;  cur_i0 = i0; cur_i1 = i1; cur_pc = pc; cur_fl = fl;
    cur_occ  = model_q.size();
    in_valid = v;
    in_inst0 = i0;
    in_inst1 = i1;
    in_meta0 = mk_meta(i0);
    in_meta1 = mk_meta(i1);
    pop_cnt  = pc;
    flush    = fl;
  endtask

  // Clock the cycle in, then update the scoreboard the way the queue should.
  task automatic drive_commit();
    int  req;
    int  av;
    int  eff;
    bit  rdy;
    @(posedge clk);
    #1;
    rdy = (DEPTH - cur_occ) >= 2;
    if (cur_fl) begin
      model_q.delete();
    end else begin
      req = (cur_pc == 2'd0) ? 0 : (cur_pc == 2'd1) ? 1 : 2;
      av  = (cur_occ >= 2) ? 2 : cur_occ;
      eff = (req < av) ? req : av;
      for (int k = 0; k < eff; k++) void'(model_q.pop_front());
      if (rdy && cur_v == 2'b01) begin
        model_q.push_back('{inst: cur_i0, meta: mk_meta(cur_i0)});
      end else if (rdy && cur_v == 2'b11) begin
        model_q.push_back('{inst: cur_i0, meta: mk_meta(cur_i0)});
        model_q.push_back('{inst: cur_i1, meta: mk_meta(cur_i1)});
      end
    end
    in_valid = 2'b00;
    pop_cnt  = 2'd0;
    flush    = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] pc,
                       input logic fl);
    drive_set(v, i0, i1, pc, fl);
    drive_commit();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 2'b00 || empty !== 1'b1 || in_ready !== 1'b1 ||
        nearly_full !== 1'b0 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_status: out_valid=%b empty=%b in_ready=%b nf=%b count=%0d want 00 1 1 0 0",
               out_valid, empty, in_ready, nearly_full, count);
    end
    tests_run++;
    if (out_inst0 !== NOP || out_inst1 !== NOP || out_meta0 !== '0 || out_meta1 !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: inst0=%h inst1=%h meta0=%h meta1=%h want NOP/0",
               out_inst0, out_inst1, out_meta0, out_meta1);
    end
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic test_pair_write();
    drive_set(2'b11, 32'hA000_000A, 32'hB000_000B, 2'd0, 1'b0);
    #1;
    tests_run++;
    if (out_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL no_bypass: out_valid=%b want 00", out_valid);
    end
    drive_commit();
    tests_run++;
    if (out_valid !== 2'b11 || count !== 5'd2) begin
      tests_failed++;
      $display("FAIL pair_status: out_valid=%b count=%0d want 11 2", out_valid, count);
    end
    tests_run++;
    if (out_inst0 !== 32'hA000_000A || out_inst1 !== 32'hB000_000B ||
        out_meta0 !== model_q[0].meta || out_meta1 !== model_q[1].meta) begin
      tests_failed++;
      $display("FAIL pair_data: inst0=%h inst1=%h want a000000a b000000b", out_inst0, out_inst1);
    end
  endtask

  task automatic test_simultaneous();
    drive(2'b01, 32'hC000_000C, 32'h0, 2'd0, 1'b0);
    drive(2'b11, 32'hD000_000D, 32'hE000_000E, 2'd1, 1'b0);
    tests_run++;
    if (count !== 5'd4 || out_inst0 !== 32'hB000_000B || out_inst1 !== 32'hC000_000C) begin
      tests_failed++;
      $display("FAIL simul_push_pop: count=%0d inst0=%h inst1=%h want 4 b000000b c000000c",
               count, out_inst0, out_inst1);
    end
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
  endtask

  task automatic test_half_mask();
    drive(2'b10, 32'hBAD0_0001, 32'hBAD0_0002, 2'd0, 1'b0);
    tests_run++;
    if (count !== 5'd0 || out_valid !== 2'b00 || count !== 5'(model_q.size())) begin
      tests_failed++;
      $display("FAIL mask_10: count=%0d out_valid=%b want 0 00", count, out_valid);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 7; k++) begin
      drive(2'b11, 32'h1000_0000 + 32'(2*k), 32'h1000_0001 + 32'(2*k), 2'd0, 1'b0);
      if (k == 5) begin
        tests_run++;
        if (count !== 5'd12 || nearly_full !== 1'b0) begin
          tests_failed++;
          $display("FAIL afull_edge_12: count=%0d nf=%b want 12 0", count, nearly_full);
        end
      end
    end
    tests_run++;
    if (count !== 5'd14 || in_ready !== 1'b1 || nearly_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_14: count=%0d in_ready=%b nf=%b want 14 1 1", count, in_ready, nearly_full);
    end
    drive(2'b01, 32'h1000_000E, 32'h0, 2'd0, 1'b0);
    tests_run++;
    if (count !== 5'd15 || in_ready !== 1'b0 || nearly_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_15: count=%0d in_ready=%b nf=%b want 15 0 1", count, in_ready, nearly_full);
    end
    drive(2'b01, 32'hDEAD_0001, 32'h0, 2'd0, 1'b0);
    tests_run++;
    if (count !== 5'd15) begin
      tests_failed++;
      $display("FAIL drop_when_full: count=%0d want 15", count);
    end
    drive(2'b11, 32'hDEAD_0002, 32'hDEAD_0003, 2'd2, 1'b0);
    tests_run++;
    if (count !== 5'd13 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_pop_credit: count=%0d in_ready=%b want 13 1", count, in_ready);
    end
    tests_run++;
    if (out_inst0 !== 32'h1000_0002 || out_inst0 !== model_q[0].inst) begin
      tests_failed++;
      $display("FAIL full_head: inst0=%h want 10000002", out_inst0);
    end
    // Drain everything and confirm the dropped writes never appear.
    while (model_q.size() > 0) begin
      tests_run++;
      if (out_inst0 !== model_q[0].inst) begin
        tests_failed++;
        $display("FAIL drain_order: inst0=%h want %h", out_inst0, model_q[0].inst);
      end
      drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    end
    tests_run++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seq;
    seq = 32'h2000_0000;
    drive(2'b11, seq, seq + 1, 2'd0, 1'b0);
    drive(2'b11, seq + 2, seq + 3, 2'd0, 1'b0);
    seq = seq + 4;
    for (int k = 0; k < 20; k++) begin
      tests_run++;
      if (out_inst0 !== model_q[0].inst || out_inst1 !== model_q[1].inst ||
          out_meta1 !== model_q[1].meta) begin
        tests_failed++;
        $display("FAIL wrap_order[%0d]: inst0=%h inst1=%h want %h %h",
                 k, out_inst0, out_inst1, model_q[0].inst, model_q[1].inst);
      end
      drive(2'b11, seq, seq + 1, 2'd2, 1'b0);
      seq = seq + 2;
      tests_run++;
      if (count !== 5'd4) begin
        tests_failed++;
        $display("FAIL wrap_count[%0d]: count=%0d want 4", k, count);
      end
    end
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
  endtask

  task automatic test_underflow();
    drive(2'b01, 32'h3000_0001, 32'h0, 2'd0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 2'b00 ||
        out_inst0 !== NOP || out_meta0 !== '0) begin
      tests_failed++;
      $display("FAIL pop2_on_1: count=%0d empty=%b inst0=%h meta0=%h want 0 1 NOP 0",
               count, empty, out_inst0, out_meta0);
    end
    drive(2'b11, 32'h3000_0002, 32'h3000_0003, 2'd0, 1'b0);
    drive(2'b01, 32'h3000_0004, 32'h0, 2'd3, 1'b0);
    tests_run++;
    if (count !== 5'd1 || out_inst0 !== 32'h3000_0004) begin
      tests_failed++;
      $display("FAIL pop3_as_2: count=%0d inst0=%h want 1 30000004", count, out_inst0);
    end
    drive(2'b00, 32'h0, 32'h0, 2'd3, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop_on_empty: count=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) drive(2'b11, 32'h4000_0000 + 32'(2*k), 32'h4000_0001 + 32'(2*k), 2'd0, 1'b0);
    tests_run++;
    if (count !== 5'd6) begin
      tests_failed++;
      $display("FAIL flush_prefill: count=%0d want 6", count);
    end
    drive(2'b11, 32'h4000_00F0, 32'h4000_00F1, 2'd2, 1'b1);
    tests_run++;
    if (count !== 5'd0 || out_valid !== 2'b00 || out_inst0 !== NOP || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_with_write: count=%0d out_valid=%b inst0=%h want 0 00 NOP",
               count, out_valid, out_inst0);
    end
    drive(2'b01, 32'h4000_0100, 32'h0, 2'd0, 1'b0);
    tests_run++;
    if (out_valid !== 2'b01 || out_inst0 !== 32'h4000_0100) begin
      tests_failed++;
      $display("FAIL after_flush: out_valid=%b inst0=%h want 01 40000100", out_valid, out_inst0);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b11, 32'h5000_0001, 32'h5000_0002, 2'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 2'b00 || count !== 5'd0 || empty !== 1'b1 || in_ready !== 1'b1 ||
        out_inst0 !== NOP || out_meta0 !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: out_valid=%b count=%0d empty=%b inst0=%h want 00 0 1 NOP",
               out_valid, count, empty, out_inst0);
    end
    model_q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b01, 32'h5000_0AAA, 32'h0, 2'd0, 1'b0);
    tests_run++;
    if (out_valid !== 2'b01 || out_inst0 !== 32'h5000_0AAA || out_inst1 !== NOP ||
        out_meta1 !== '0 || out_meta0 !== model_q[0].meta) begin
      tests_failed++;
      $display("FAIL first_after_reset: out_valid=%b inst0=%h inst1=%h want 01 50000aaa NOP",
               out_valid, out_inst0, out_inst1);
    end
  endtask

  initial begin
    test_reset();
    test_pair_write();
    test_simultaneous();
    test_half_mask();
    test_full();
    test_wrap();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
